// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue
//
// In-order queue of in-flight conditional branches sitting between decode and
// the tournament predictor. Decode pushes {pc, predicted direction, predicted
// target}; the memory stage resolves the oldest entry, which is popped, checked
// against the prediction and turned into a registered predictor update strobe
// plus an optional mispredict redirect. Saturating statistics are kept.
//
// Ports:
//   clk, reset               core clock, synchronous active-high reset
//   dec_valid/pc/prediction/target
//                            branch seen at decode (enqueue request)
//   res_valid/taken/target   resolution of the oldest in-flight branch
//   flush                    discard all in-flight entries
//   branch_mem_sig           one-cycle predictor update strobe
//   actual_branch_decision   resolved direction (held between strobes)
//   update_branch_addr       PC of the resolved branch (held between strobes)
//   mispredict               one-cycle redirect pulse
//   recovery_pc              redirect PC, 0 on a correct resolution (held)
//   full, inflight_count     occupancy status
//   overflow_err             sticky: enqueue attempted while full
//   underflow_err            sticky: resolve attempted while empty
//   stat_branches            resolved-branch counter, saturating
//   stat_mispredicts         mispredicted-branch counter, saturating

module branch_resolve_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2,
  parameter int unsigned CNT_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dec_valid,
  input  logic [31:0]       dec_pc,
  input  logic              dec_prediction,
  input  logic [31:0]       dec_target,
  input  logic              res_valid,
  input  logic              res_taken,
  input  logic [31:0]       res_target,
  input  logic              flush,
  output logic              branch_mem_sig,
  output logic              actual_branch_decision,
  output logic [31:0]       update_branch_addr,
  output logic              mispredict,
  output logic [31:0]       recovery_pc,
  output logic              full,
  output logic [PTR_W:0]    inflight_count,
  output logic              overflow_err,
  output logic              underflow_err,
  output logic [CNT_W-1:0]  stat_branches,
  output logic [CNT_W-1:0]  stat_mispredicts
);

  localparam logic [PTR_W:0]   FullCnt = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W-1:0] PtrOne  = PTR_W'(1);
  localparam logic [PTR_W:0]   CntOne  = (PTR_W + 1)'(1);

  // Entry storage; never reset, only valid between head and tail.
  logic [31:0] pc_q   [DEPTH];
  logic        pred_q [DEPTH];
  logic [31:0] tgt_q  [DEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;

  logic             strobe_q, strobe_d;
  logic             taken_q, taken_d;
  logic [31:0]      upd_pc_q, upd_pc_d;
  logic             mis_q, mis_d;
  logic [31:0]      rec_pc_q, rec_pc_d;
  logic             over_q, over_d;
  logic             under_q, under_d;
  logic [CNT_W-1:0] stat_br_q, stat_br_d;
  logic [CNT_W-1:0] stat_mis_q, stat_mis_d;

  logic        full_w;
  logic        empty_w;
  logic        pop;
  logic        mis;
  logic        squash;
  logic        enq;
  logic [31:0] head_pc;
  logic        head_pred;
  logic [31:0] head_tgt;
  logic [31:0] redirect_pc;

  assign full_w    = (count_q == FullCnt);
  assign empty_w   = (count_q == '0);
  assign head_pc   = pc_q[head_q];
  assign head_pred = pred_q[head_q];
  assign head_tgt  = tgt_q[head_q];

  assign pop = res_valid & ~empty_w;

  // Wrong direction, or right "taken" direction to the wrong place.
  assign mis = (res_taken != head_pred) |
               (res_taken & head_pred & (res_target != head_tgt));

  assign redirect_pc = res_taken ? res_target : head_pc + 32'd4;

  // A mispredicting pop kills everything younger, including this cycle's decode.
  assign squash = pop & mis;

  // Full is judged before the same-cycle pop, so a full queue drops the push.
  assign enq = dec_valid & ~full_w & ~flush & ~squash;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;

    if (pop) begin
      head_d = head_q + PtrOne;
    end

    if (squash) begin
      tail_d  = head_q + PtrOne;
      count_d = '0;
    end else if (flush) begin
      // The pop (if any) has already been taken, so collapse onto the new head.
      tail_d  = head_d;
      count_d = '0;
    end else begin
      if (enq) begin
        tail_d = tail_q + PtrOne;
      end
      unique case ({enq, pop})
        2'b10:   count_d = count_q + CntOne;
        2'b01:   count_d = count_q - CntOne;
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    strobe_d   = pop;
    mis_d      = squash;
    taken_d    = taken_q;
    upd_pc_d   = upd_pc_q;
    rec_pc_d   = rec_pc_q;
    over_d     = over_q;
    under_d    = under_q;
    stat_br_d  = stat_br_q;
    stat_mis_d = stat_mis_q;

    if (pop) begin
      taken_d  = res_taken;
      upd_pc_d = head_pc;
      rec_pc_d = mis ? redirect_pc : 32'd0;
      if (stat_br_q != '1) begin
        stat_br_d = stat_br_q + CNT_W'(1);
      end
      if (mis && (stat_mis_q != '1)) begin
        stat_mis_d = stat_mis_q + CNT_W'(1);
      end
    end

    // Wrong-path and flushed decodes are discarded silently, not overflows.
    if (dec_valid && full_w && !flush && !squash) begin
      over_d = 1'b1;
    end

    if (res_valid && empty_w) begin
      under_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      strobe_q   <= 1'b0;
      taken_q    <= 1'b0;
      upd_pc_q   <= '0;
      mis_q      <= 1'b0;
      rec_pc_q   <= '0;
      over_q     <= 1'b0;
      under_q    <= 1'b0;
      stat_br_q  <= '0;
      stat_mis_q <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      strobe_q   <= strobe_d;
      taken_q    <= taken_d;
      upd_pc_q   <= upd_pc_d;
      mis_q      <= mis_d;
      rec_pc_q   <= rec_pc_d;
      over_q     <= over_d;
      under_q    <= under_d;
      stat_br_q  <= stat_br_d;
      stat_mis_q <= stat_mis_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && enq) begin
      pc_q[tail_q]   <= dec_pc;
      pred_q[tail_q] <= dec_prediction;
      tgt_q[tail_q]  <= dec_target;
    end
  end

  assign branch_mem_sig         = strobe_q;
  assign actual_branch_decision = taken_q;
  assign update_branch_addr     = upd_pc_q;
  assign mispredict             = mis_q;
  assign recovery_pc            = rec_pc_q;
  assign full                   = full_w;
  assign inflight_count         = count_q;
  assign overflow_err           = over_q;
  assign underflow_err          = under_q;
  assign stat_branches          = stat_br_q;
  assign stat_mispredicts       = stat_mis_q;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Self-checking bench for branch_resolve_queue: a reference queue model runs
// alongside the DUT and pushes the expected update strobe contents into a
// scoreboard whenever a resolving cycle is driven.

module tb_branch_resolve_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        dec_valid;
  logic [31:0] dec_pc;
  logic        dec_prediction;
  logic [31:0] dec_target;
  logic        res_valid;
  logic        res_taken;
  logic [31:0] res_target;
  logic        flush;
  logic        branch_mem_sig;
  logic        actual_branch_decision;
  logic [31:0] update_branch_addr;
  logic        mispredict;
  logic [31:0] recovery_pc;
  logic        full;
  logic [2:0]  inflight_count;
  logic        overflow_err;
  logic        underflow_err;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;

  branch_resolve_queue #(
    .DEPTH(4),
    .PTR_W(2),
    .CNT_W(32)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .dec_valid              (dec_valid),
    .dec_pc                 (dec_pc),
    .dec_prediction         (dec_prediction),
    .dec_target             (dec_target),
    .res_valid              (res_valid),
    .res_taken              (res_taken),
    .res_target             (res_target),
    .flush                  (flush),
    .branch_mem_sig         (branch_mem_sig),
    .actual_branch_decision (actual_branch_decision),
    .update_branch_addr     (update_branch_addr),
    .mispredict             (mispredict),
    .recovery_pc            (recovery_pc),
    .full                   (full),
    .inflight_count         (inflight_count),
    .overflow_err           (overflow_err),
    .underflow_err          (underflow_err),
    .stat_branches          (stat_branches),
    .stat_mispredicts       (stat_mispredicts)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        pred;
    logic [31:0] tgt;
  } ent_t;

  typedef struct {
    logic [31:0] pc;
    logic        taken;
    logic        mis;
    logic [31:0] rec;
  } exp_t;

  ent_t mq[$];
  exp_t exp_q[$];
  exp_t cur;
  logic        m_over;
  logic        m_under;
  logic [31:0] m_br;
  logic [31:0] m_mis;

  int errors = 0;
  int checks = 0;

  task automatic idle_inputs();
    dec_valid      = 1'b0;
    dec_pc         = '0;
    dec_prediction = 1'b0;
    dec_target     = '0;
    res_valid      = 1'b0;
    res_taken      = 1'b0;
    res_target     = '0;
    flush          = 1'b0;
  endtask

  // Drive one cycle of stimulus and advance the reference model.
  task automatic drive(input logic dv, input logic [31:0] pc, input logic pred,
                       input logic [31:0] tgt, input logic rv, input logic rt,
                       input logic [31:0] rtgt, input logic fl);
    ent_t h;
    exp_t x;
    logic full_pre, pop, mis;
    dec_valid      = dv;
    dec_pc         = pc;
    dec_prediction = pred;
    dec_target     = tgt;
    res_valid      = rv;
    res_taken      = rt;
    res_target     = rtgt;
    flush          = fl;
    full_pre = (mq.size() == 4);
    pop      = rv && (mq.size() > 0);
    mis      = 1'b0;
    if (rv && mq.size() == 0) m_under = 1'b1;
    if (pop) begin
      h = mq.pop_front();
      mis = (rt != h.pred) || (rt && h.pred && (rtgt != h.tgt));
      x.pc    = h.pc;
      x.taken = rt;
      x.mis   = mis;
      x.rec   = mis ? (rt ? rtgt : h.pc + 32'd4) : 32'd0;
      exp_q.push_back(x);
      m_br = m_br + 1;
      if (mis) m_mis = m_mis + 1;
    end
    if (pop && mis) mq.delete();
    else if (fl) mq.delete();
    else if (dv) begin
      if (full_pre) m_over = 1'b1;
      else mq.push_back('{pc, pred, tgt});
    end
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic enq(input logic [31:0] pc, input logic pred, input logic [31:0] tgt);
    drive(1'b1, pc, pred, tgt, 1'b0, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic res(input logic rt, input logic [31:0] rtgt);
    drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, rt, rtgt, 1'b0);
  endtask

  task automatic idle();
    drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic model_clear();
    mq.delete();
    exp_q.delete();
    m_over  = 1'b0;
    m_under = 1'b0;
    m_br    = '0;
    m_mis   = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
    checks++;
    if ({branch_mem_sig, actual_branch_decision, update_branch_addr, mispredict, recovery_pc,
         full, inflight_count, overflow_err, underflow_err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got sig=%b dec=%b addr=%h mis=%b rec=%h full=%b cnt=%0d ov=%b un=%b, want all 0",
               branch_mem_sig, actual_branch_decision, update_branch_addr, mispredict,
               recovery_pc, full, inflight_count, overflow_err, underflow_err);
    end
    checks++;
    if ({stat_branches, stat_mispredicts} !== 64'd0) begin
      errors++;
      $display("FAIL reset_stats: got br=%0d mis=%0d, want 0 0", stat_branches, stat_mispredicts);
    end
  endtask

  task automatic test_correct_taken();
    enq(32'h100, 1'b1, 32'h140);
    res(1'b1, 32'h140);
    checks++;
    cur = exp_q.pop_front();
    if ({branch_mem_sig, update_branch_addr, actual_branch_decision, mispredict, recovery_pc} !==
        {1'b1, cur.pc, cur.taken, cur.mis, cur.rec}) begin
      errors++;
      $display("FAIL t1_strobe: got sig=%b addr=%h dec=%b mis=%b rec=%h, want 1 %h %b %b %h",
               branch_mem_sig, update_branch_addr, actual_branch_decision, mispredict,
               recovery_pc, cur.pc, cur.taken, cur.mis, cur.rec);
    end
    checks++;
    if (stat_branches !== m_br || stat_mispredicts !== m_mis) begin
      errors++;
      $display("FAIL t1_stats: got br=%0d mis=%0d, want %0d %0d",
               stat_branches, stat_mispredicts, m_br, m_mis);
    end
    idle();
    checks++;
    if (branch_mem_sig !== 1'b0 || update_branch_addr !== 32'h100) begin
      errors++;
      $display("FAIL t1_strobe_drop: got sig=%b addr=%h, want 0 00000100",
               branch_mem_sig, update_branch_addr);
    end
  endtask

  task automatic test_mispredict_dir();
    int n;
    enq(32'h200, 1'b1, 32'h240);
    enq(32'h208, 1'b0, 32'h300);
    res(1'b0, 32'h0);
    checks++;
    cur = exp_q.pop_front();
    if ({branch_mem_sig, update_branch_addr, actual_branch_decision, mispredict, recovery_pc} !==
        {1'b1, cur.pc, cur.taken, cur.mis, cur.rec}) begin
      errors++;
      $display("FAIL t2_strobe: got sig=%b addr=%h dec=%b mis=%b rec=%h, want 1 %h %b %b %h",
               branch_mem_sig, update_branch_addr, actual_branch_decision, mispredict,
               recovery_pc, cur.pc, cur.taken, cur.mis, cur.rec);
    end
    n = mq.size();
    checks++;
    if (inflight_count !== n[2:0] || stat_mispredicts !== m_mis) begin
      errors++;
      $display("FAIL t2_squash: got cnt=%0d smis=%0d, want %0d %0d",
               inflight_count, stat_mispredicts, n, m_mis);
    end
    res(1'b1, 32'h0);
    checks++;
    if (underflow_err !== m_under || branch_mem_sig !== 1'b0 || mispredict !== 1'b0) begin
      errors++;
      $display("FAIL t2_underflow: got un=%b sig=%b mis=%b, want %b 0 0",
               underflow_err, branch_mem_sig, mispredict, m_under);
    end
  endtask

  task automatic test_mispredict_target();
    enq(32'h300, 1'b1, 32'h340);
    res(1'b1, 32'h380);
    checks++;
    cur = exp_q.pop_front();
    if ({branch_mem_sig, update_branch_addr, actual_branch_decision, mispredict, recovery_pc} !==
        {1'b1, cur.pc, cur.taken, cur.mis, cur.rec}) begin
      errors++;
      $display("FAIL t3_strobe: got sig=%b addr=%h dec=%b mis=%b rec=%h, want 1 %h %b %b %h",
               branch_mem_sig, update_branch_addr, actual_branch_decision, mispredict,
               recovery_pc, cur.pc, cur.taken, cur.mis, cur.rec);
    end
  endtask

  task automatic test_overflow_fifo();
    int n;
    for (int i = 0; i < 4; i++) enq(32'h400 + 32'(i * 8), i[0], 32'h440 + 32'(i * 8));
    checks++;
    if (full !== 1'b1 || inflight_count !== 3'd4) begin
      errors++;
      $display("FAIL t4_full: got full=%b cnt=%0d, want 1 4", full, inflight_count);
    end
    enq(32'h4f0, 1'b1, 32'h500);
    n = mq.size();
    checks++;
    if (overflow_err !== m_over || inflight_count !== n[2:0]) begin
      errors++;
      $display("FAIL t4_overflow: got ov=%b cnt=%0d, want %b %0d",
               overflow_err, inflight_count, m_over, n);
    end
    for (int i = 0; i < 4; i++) begin
      res(i[0], 32'h440 + 32'(i * 8));
      checks++;
      cur = exp_q.pop_front();
      if ({branch_mem_sig, update_branch_addr, mispredict} !== {1'b1, cur.pc, cur.mis}) begin
        errors++;
        $display("FAIL t4_fifo_%0d: got sig=%b addr=%h mis=%b, want 1 %h %b",
                 i, branch_mem_sig, update_branch_addr, mispredict, cur.pc, cur.mis);
      end
    end
    checks++;
    if (full !== 1'b0 || inflight_count !== 3'd0) begin
      errors++;
      $display("FAIL t4_drained: got full=%b cnt=%0d, want 0 0", full, inflight_count);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    enq(32'h500, 1'b0, 32'h540);
    enq(32'h508, 1'b1, 32'h548);
    // Correct pop of 0x500 alongside a new push.
    drive(1'b1, 32'h510, 1'b0, 32'h550, 1'b1, 1'b0, 32'h0, 1'b0);
    n = mq.size();
    checks++;
    cur = exp_q.pop_front();
    if (inflight_count !== n[2:0] || branch_mem_sig !== 1'b1 || update_branch_addr !== cur.pc ||
        mispredict !== cur.mis) begin
      errors++;
      $display("FAIL t5_pop_push: got cnt=%0d sig=%b addr=%h mis=%b, want %0d 1 %h %b",
               inflight_count, branch_mem_sig, update_branch_addr, mispredict, n, cur.pc, cur.mis);
    end
    // Mispredicting pop of 0x508 (predicted taken, actually not) with a wrong-path push.
    drive(1'b1, 32'h518, 1'b1, 32'h558, 1'b1, 1'b0, 32'h0, 1'b0);
    n = mq.size();
    checks++;
    cur = exp_q.pop_front();
    if (inflight_count !== n[2:0] || mispredict !== 1'b1 || recovery_pc !== cur.rec ||
        overflow_err !== m_over) begin
      errors++;
      $display("FAIL t5_squash: got cnt=%0d mis=%b rec=%h ov=%b, want %0d 1 %h %b",
               inflight_count, mispredict, recovery_pc, overflow_err, n, cur.rec, m_over);
    end
    // Fresh entry after squash must be the one popped next.
    enq(32'h600, 1'b0, 32'h640);
    res(1'b0, 32'h0);
    checks++;
    cur = exp_q.pop_front();
    if (update_branch_addr !== cur.pc || branch_mem_sig !== 1'b1 || mispredict !== 1'b0) begin
      errors++;
      $display("FAIL t5_after_squash: got addr=%h sig=%b mis=%b, want %h 1 0",
               update_branch_addr, branch_mem_sig, mispredict, cur.pc);
    end
    // Full queue: a same-cycle pop does not make room for the push.
    for (int i = 0; i < 4; i++) enq(32'h680 + 32'(i * 4), 1'b0, 32'h0);
    drive(1'b1, 32'h6f0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    void'(exp_q.pop_front());
    n = mq.size();
    checks++;
    if (inflight_count !== n[2:0] || full !== 1'b0) begin
      errors++;
      $display("FAIL t5_full_drop: got cnt=%0d full=%b, want %0d 0", inflight_count, full, n);
    end
    for (int i = 0; i < 3; i++) res(1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      cur = exp_q.pop_front();
      checks++;
      if (cur.pc !== 32'h684 + 32'(i * 4)) begin
        errors++;
        $display("FAIL t5_model_order_%0d: got %h, want %h", i, cur.pc, 32'h684 + 32'(i * 4));
      end
    end
    checks++;
    if (update_branch_addr !== 32'h68c || inflight_count !== 3'd0) begin
      errors++;
      $display("FAIL t5_drain_last: got addr=%h cnt=%0d, want 0000068c 0",
               update_branch_addr, inflight_count);
    end
  endtask

  task automatic test_flush_reset();
    for (int i = 0; i < 3; i++) enq(32'h700 + 32'(i * 4), 1'b1, 32'h740);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h740, 1'b1);
    checks++;
    cur = exp_q.pop_front();
    if (branch_mem_sig !== 1'b1 || update_branch_addr !== cur.pc || mispredict !== 1'b0 ||
        inflight_count !== 3'd0 || stat_branches !== m_br) begin
      errors++;
      $display("FAIL t6_flush: got sig=%b addr=%h mis=%b cnt=%0d br=%0d, want 1 %h 0 0 %0d",
               branch_mem_sig, update_branch_addr, mispredict, inflight_count, stat_branches,
               cur.pc, m_br);
    end
    enq(32'h800, 1'b0, 32'h0);
    res(1'b0, 32'h0);
    checks++;
    cur = exp_q.pop_front();
    if (branch_mem_sig !== 1'b1 || update_branch_addr !== cur.pc) begin
      errors++;
      $display("FAIL t6_after_flush: got sig=%b addr=%h, want 1 %h",
               branch_mem_sig, update_branch_addr, cur.pc);
    end
    enq(32'h900, 1'b1, 32'h940);
    enq(32'h908, 1'b1, 32'h948);
    // Reset wins over a simultaneous resolve and decode.
    reset = 1'b1;
    dec_valid = 1'b1;
    dec_pc = 32'h910;
    res_valid = 1'b1;
    res_taken = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle_inputs();
    model_clear();
    checks++;
    if ({branch_mem_sig, actual_branch_decision, update_branch_addr, mispredict, recovery_pc,
         full, inflight_count, overflow_err, underflow_err} !== '0) begin
      errors++;
      $display("FAIL t6_reset_outputs: got sig=%b dec=%b addr=%h mis=%b rec=%h full=%b cnt=%0d ov=%b un=%b, want all 0",
               branch_mem_sig, actual_branch_decision, update_branch_addr, mispredict,
               recovery_pc, full, inflight_count, overflow_err, underflow_err);
    end
    checks++;
    if (stat_branches !== 32'd0 || stat_mispredicts !== 32'd0) begin
      errors++;
      $display("FAIL t6_reset_stats: got br=%0d mis=%0d, want 0 0",
               stat_branches, stat_mispredicts);
    end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    model_clear();
    test_reset();
    test_correct_taken();
    test_mispredict_dir();
    test_mispredict_target();
    test_overflow_fifo();
    test_back_to_back();
    test_flush_reset();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: got %0d pending, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_resolve_queue.md
Name: branch_resolve_queue

Overview:
- Sits between decode and the tournament predictor.
- Records every branch the predictor sees at decode (PC, predicted direction, predicted target) in an in-order queue of in-flight branches.
- Pops the oldest entry when the memory stage resolves a branch, checks the resolution against the prediction, raises mispredict with a recovery PC, and emits the one-cycle update strobe, PC and outcome that drive the predictor's history-table update inputs.
- Keeps saturating branch and mispredict statistics counters.

Parameters:
DEPTH, 4, number of in-flight entries; power of two, at least 2.
PTR_W, 2, log2(DEPTH).
CNT_W, 32, width of statistics counters.

Ports:
clk  input  1  core clock; all state updates on posedge.
reset  input  1  synchronous, active-high reset.
dec_valid  input  1  decode stage has a conditional branch this cycle.
dec_pc  input  32  PC of the decoding branch.
dec_prediction  input  1  predicted direction (1 = taken).
dec_target  input  32  predicted taken target (pc + offset).
res_valid  input  1  memory stage resolves the oldest in-flight branch.
res_taken  input  1  actual branch decision.
res_target  input  32  actual computed taken target.
flush  input  1  external pipeline flush (trap or redirect): discard all entries.
branch_mem_sig  output  1  one-cycle update strobe to predictor.
actual_branch_decision  output  1  resolved direction, valid with branch_mem_sig.
update_branch_addr  output  32  PC of the resolved branch, valid with branch_mem_sig.
mispredict  output  1  one-cycle pulse: fetch must redirect.
recovery_pc  output  32  redirect PC, valid with mispredict.
full  output  1  queue holds DEPTH entries.
inflight_count  output  PTR_W+1  current occupancy.
overflow_err  output  1  sticky: dec_valid accepted while full.
underflow_err  output  1  sticky: res_valid while empty.
stat_branches  output  CNT_W  resolved branches, saturating.
stat_mispredicts  output  CNT_W  mispredicted branches, saturating.

Behaviour:
- Reset (synchronous, posedge clk with reset=1):
  - head, tail and count cleared to 0.
  - All outputs 0, including sticky errors and statistics.
  - Entry storage need not be cleared.
  - Reset overrides all other inputs in the same cycle.
- Storage: circular buffer of DEPTH entries {pc, pred, target}. Head and tail pointers wrap modulo DEPTH.
- Enqueue, when dec_valid and not full: write the entry at tail, then tail+1.
- Enqueue while full:
  - The entry is dropped and overflow_err is set.
  - Queue contents are unchanged.
  - count does not change unless a pop occurs in the same cycle; the drop decision uses the pre-pop full state.
- Resolve, when res_valid and count>0:
  - Pop the head.
  - Compute mis = (res_taken != pred) | (res_taken & pred & (res_target != target)).
  - recovery_pc = res_taken ? res_target : pc + 32'd4 (modulo 2^32).
- Resolve while empty: no pop, no strobe, underflow_err set.
- Output timing: all outputs are registered; latency is 1 cycle from res_valid to outputs.
  - In the cycle after a valid pop: branch_mem_sig=1, actual_branch_decision=res_taken, update_branch_addr=popped pc, mispredict=mis, recovery_pc as computed. recovery_pc is 0 when mis=0.
  - In all other cycles, branch_mem_sig and mispredict return to 0.
  - actual_branch_decision, update_branch_addr and recovery_pc hold their last values when not strobed.
- Mispredict squash:
  - On a popping cycle with mis=1, every younger entry is discarded: tail := head+1 and count := 0.
  - A dec_valid in the same cycle is also discarded; it is on the wrong path. This is not an overflow.
- flush:
  - Sets count to 0 and tail := head.
  - Suppresses any enqueue in the same cycle.
  - A res_valid in the same cycle is still processed first, so its strobe and statistics are emitted; the flush then clears the rest.
- Simultaneous enqueue and non-mispredicting pop: both take effect, count unchanged. When the queue was full, the pre-pop full state still drops the enqueue (see above).
- Statistics:
  - stat_branches increments on every valid pop.
  - stat_mispredicts increments when mis=1.
  - Both saturate at all-ones.
- full = (count == DEPTH). inflight_count = count.

Test Plan:
1. Reset, then enqueue pc=0x100 pred=1 target=0x140; resolve taken, target 0x140 -> next cycle branch_mem_sig=1, update_branch_addr=0x100, actual_branch_decision=1, mispredict=0, stat_branches=1.
2. Enqueue pc=0x200 pred=1 target=0x240, then pc=0x208; resolve first as not-taken -> mispredict=1, recovery_pc=0x204, inflight_count=0, stat_mispredicts=1. A following res_valid sets underflow_err=1.
3. Enqueue pc=0x300 pred=1 target=0x340; resolve taken with res_target=0x380 -> mispredict=1, recovery_pc=0x380.
4. Enqueue 4 branches (full=1), then a 5th -> overflow_err=1, inflight_count=4. Four correct resolutions pop PCs in FIFO order, then full=0 and count=0.
5. In one cycle, resolve head correctly and enqueue a new branch with count=2 -> count stays 2 and the strobe carries the old head PC. Repeat with a mispredicting resolve -> count=0 and the new branch is discarded.
6. Set flush with res_valid and 3 entries -> strobe for the head, count=0. Assert reset mid-stream -> all outputs 0 next cycle and stat counters cleared.
